// File: rtl/totp_pkg.sv
// totp_pkg: shared definitions for the TOTP sequencer slice.
//   state_t  - sequencer FSM states
//   MSG_BITS - width of the TOTP counter message streamed to the core
//   BCD_W    - width of one decimal digit returned by the core
package totp_pkg;

  localparam int unsigned MSG_BITS = 64;
  localparam int unsigned BCD_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_MSG,
    ST_WAIT,
    ST_READ
  } state_t;

endpackage

// File: rtl/totp_step_timer.sv
// totp_step_timer: keeps the TOTP time step T.
//   clk, rst   - clock, synchronous active-high reset
//   tick       - 1 Hz strobe, one cycle wide
//   t_load     - load t_value into T (wins over a wrapping tick)
//   t_value    - new T
//   step       - current T
//   step_pulse - high in the cycle a new T is being taken (wrap or load)
module totp_step_timer
  import totp_pkg::*;
#(
  parameter int unsigned STEP_TICKS = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                t_load,
  input  logic [MSG_BITS-1:0] t_value,
  output logic [MSG_BITS-1:0] step,
  output logic                step_pulse
);

  localparam int unsigned SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  logic [SW-1:0] sec;
  logic          wrap;

  assign wrap       = tick && (sec == SW'(STEP_TICKS - 1));
  // Combinational so the trigger reaches the FSM's pending flag on the same edge.
  assign step_pulse = t_load || wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      sec  <= '0;
      step <= '0;
    end else if (t_load) begin
      step <= t_value;
      sec  <= '0;
    end else if (tick) begin
      if (wrap) begin
        sec  <= '0;
        step <= step + MSG_BITS'(1);
      end else begin
        sec <= sec + SW'(1);
      end
    end
  end

endmodule

// File: rtl/totp_sequencer.sv
// totp_sequencer: autonomous driver for the serial HMAC/TOTP core.
// On each new time step (or start request) streams the key and the 64-bit T
// MSB first, waits for core_ready (bounded by TIMEOUT) and reads back DIGITS
// BCD digits through core_sel.
//   clk, rst            - clock, synchronous active-high reset
//   tick, start, t_load - step strobe, recompute request, T load
//   t_value             - value loaded into T
//   key_idx / key_bit   - key store address / combinational key bit
//   core_data           - serial bit to the core
//   core_key_en/msg_en  - key / message shift enables
//   core_sel / core_bcd - digit select / selected digit
//   core_ready          - core result valid
//   code, valid         - packed BCD code (digit 0 in [3:0]), code is current
//   busy                - sequencer not idle
//   timeout_err         - sticky WAIT timeout flag
//   step                - current T
module totp_sequencer
  import totp_pkg::*;
#(
  parameter int unsigned KEY_BITS   = 160,
  parameter int unsigned STEP_TICKS = 30,
  parameter int unsigned DIGITS     = 6,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic                        start,
  input  logic                        t_load,
  input  logic [MSG_BITS-1:0]         t_value,
  output logic [$clog2(KEY_BITS)-1:0] key_idx,
  input  logic                        key_bit,
  output logic                        core_data,
  output logic                        core_key_en,
  output logic                        core_msg_en,
  output logic [2:0]                  core_sel,
  input  logic                        core_ready,
  input  logic [BCD_W-1:0]            core_bcd,
  output logic [BCD_W*DIGITS-1:0]     code,
  output logic                        valid,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [MSG_BITS-1:0]         step
);

  localparam int unsigned KW = $clog2(KEY_BITS);
  localparam int unsigned IW = $clog2((KEY_BITS > MSG_BITS) ? KEY_BITS : MSG_BITS);
  localparam int unsigned MW = $clog2(MSG_BITS);
  localparam int unsigned WW = $clog2(TIMEOUT);

  state_t              state;
  logic                pending;
  logic                step_pulse;
  logic [MSG_BITS-1:0] t_run;
  logic [IW-1:0]       idx;
  logic [WW-1:0]       wcnt;
  logic [2:0]          d;
  logic                ph;

  totp_step_timer #(
    .STEP_TICKS(STEP_TICKS)
  ) u_step_timer (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .t_load    (t_load),
    .t_value   (t_value),
    .step      (step),
    .step_pulse(step_pulse)
  );

  assign core_key_en = (state == ST_KEY);
  assign core_msg_en = (state == ST_MSG);
  assign key_idx     = (state == ST_KEY) ? idx[KW-1:0] : KW'(KEY_BITS - 1);

  always_comb begin
    core_data = 1'b0;
    if (state == ST_KEY) begin
      core_data = key_bit;
    end else if (state == ST_MSG) begin
      core_data = t_run[idx[MW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      t_run       <= '0;
      idx         <= IW'(KEY_BITS - 1);
      wcnt        <= '0;
      d           <= '0;
      ph          <= 1'b0;
      code        <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      core_sel    <= '0;
    end else begin
      pending <= pending | start | step_pulse;
      unique case (state)
        ST_IDLE: begin
          if (pending) begin
            // A trigger arriving in the consuming cycle must survive.
            pending     <= start | step_pulse;
            t_run       <= step;
            valid       <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            idx         <= IW'(KEY_BITS - 1);
            state       <= ST_KEY;
          end
        end
        ST_KEY: begin
          if (idx == '0) begin
            idx   <= IW'(MSG_BITS - 1);
            state <= ST_MSG;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        ST_MSG: begin
          if (idx == '0) begin
            wcnt  <= '0;
            state <= ST_WAIT;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        ST_WAIT: begin
          if (core_ready) begin
            d        <= '0;
            ph       <= 1'b0;
            core_sel <= '0;
            state    <= ST_READ;
          end else if (wcnt == WW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            valid       <= 1'b0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        ST_READ: begin
          // ph=0: core_sel already shows d; ph=1: capture the digit.
          if (!ph) begin
            ph <= 1'b1;
          end else begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
              if (d == 3'(i)) code[BCD_W*i +: BCD_W] <= core_bcd;
            end
            if (d == 3'(DIGITS - 1)) begin
              valid <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              d        <= d + 3'd1;
              core_sel <= d + 3'd1;
              ph       <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_totp_sequencer.sv
// Bench for totp_sequencer with a behavioural HMAC-SHA1 TOTP core model.
module tb_totp_sequencer;

  localparam int unsigned KEY_BITS   = 160;
  localparam int unsigned STEP_TICKS = 3;
  localparam int unsigned DIGITS     = 6;
  localparam int unsigned TIMEOUT    = 16;
  localparam logic [159:0] KEY = "12345678901234567890";

  logic        clk = 1'b0;
  logic        rst, tick, start, t_load;
  logic [63:0] t_value;
  logic [7:0]  key_idx;
  logic        key_bit, core_data, core_key_en, core_msg_en, core_ready;
  logic [2:0]  core_sel;
  logic [3:0]  core_bcd;
  logic [23:0] code;
  logic        valid, busy, timeout_err;
  logic [63:0] step;

  int total = 0;
  int bad   = 0;
  int key_cnt = 0, msg_cnt = 0, wait_cnt = 0, runs = 0;
  logic prev_busy = 1'b0;

  always #5 clk = ~clk;

  totp_sequencer #(
    .KEY_BITS  (KEY_BITS),
    .STEP_TICKS(STEP_TICKS),
    .DIGITS    (DIGITS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .t_load     (t_load),
    .t_value    (t_value),
    .key_idx    (key_idx),
    .key_bit    (key_bit),
    .core_data  (core_data),
    .core_key_en(core_key_en),
    .core_msg_en(core_msg_en),
    .core_sel   (core_sel),
    .core_ready (core_ready),
    .core_bcd   (core_bcd),
    .code       (code),
    .valid      (valid),
    .busy       (busy),
    .timeout_err(timeout_err),
    .step       (step)
  );

  // ---------------- reference HMAC-SHA1 / TOTP ----------------
  function automatic logic [159:0] sha1(input logic [7:0] msg [128], input int unsigned len);
    logic [7:0]  b [128];
    logic [31:0] w [80];
    logic [31:0] h [5];
    logic [31:0] a, bb, c, dd, e, f, k, tmp;
    logic [63:0] bitlen;
    int unsigned nblk;
    for (int unsigned i = 0; i < 128; i++) b[i] = (i < len) ? msg[i] : 8'h00;
    b[len] = 8'h80;
    nblk   = (len + 8) / 64 + 1;
    bitlen = 64'(len) * 64'd8;
    for (int unsigned i = 0; i < 8; i++) b[nblk*64-1-i] = bitlen[8*i +: 8];
    h = '{32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
    for (int unsigned blk = 0; blk < nblk; blk++) begin
      for (int unsigned t = 0; t < 16; t++)
        w[t] = {b[blk*64+4*t], b[blk*64+4*t+1], b[blk*64+4*t+2], b[blk*64+4*t+3]};
      for (int unsigned t = 16; t < 80; t++) begin
        tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
        w[t] = {tmp[30:0], tmp[31]};
      end
      a = h[0]; bb = h[1]; c = h[2]; dd = h[3]; e = h[4];
      for (int unsigned t = 0; t < 80; t++) begin
        if (t < 20)      begin f = (bb & c) | (~bb & dd);           k = 32'h5A827999; end
        else if (t < 40) begin f = bb ^ c ^ dd;                     k = 32'h6ED9EBA1; end
        else if (t < 60) begin f = (bb & c) | (bb & dd) | (c & dd); k = 32'h8F1BBCDC; end
        else             begin f = bb ^ c ^ dd;                     k = 32'hCA62C1D6; end
        tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
        e = dd; dd = c; c = {bb[1:0], bb[31:2]}; bb = a; a = tmp;
      end
      h[0] += a; h[1] += bb; h[2] += c; h[3] += dd; h[4] += e;
    end
    return {h[0], h[1], h[2], h[3], h[4]};
  endfunction

  // Eight BCD digits of the TOTP value (low digit in [3:0]).
  function automatic logic [31:0] totp_ref(input logic [159:0] key, input logic [63:0] t);
    logic [7:0]   m [128];
    logic [7:0]   hb [20];
    logic [159:0] ih, hm;
    logic [31:0]  bin, bcd;
    int unsigned  off, v;
    for (int unsigned i = 0; i < 128; i++) m[i] = 8'h00;
    for (int unsigned i = 0; i < 64; i++) m[i] = ((i < 20) ? key[159-8*i -: 8] : 8'h00) ^ 8'h36;
    for (int unsigned i = 0; i < 8; i++) m[64+i] = t[63-8*i -: 8];
    ih = sha1(m, 72);
    for (int unsigned i = 0; i < 64; i++) m[i] = ((i < 20) ? key[159-8*i -: 8] : 8'h00) ^ 8'h5c;
    for (int unsigned i = 0; i < 20; i++) m[64+i] = ih[159-8*i -: 8];
    hm = sha1(m, 84);
    for (int unsigned i = 0; i < 20; i++) hb[i] = hm[159-8*i -: 8];
    off = 32'(hb[19][3:0]);
    bin = {hb[off] & 8'h7f, hb[off+1], hb[off+2], hb[off+3]};
    v   = bin % 100000000;
    for (int unsigned i = 0; i < 8; i++) begin
      bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return bcd;
  endfunction

  function automatic logic [23:0] exp_code(input logic [63:0] t);
    logic [31:0] full;
    full = totp_ref(KEY, t);
    return full[23:0];
  endfunction

  // ---------------- key store and core model ----------------
  logic [159:0] key_mem = KEY;
  logic [159:0] ksr;
  logic [63:0]  msr;
  logic [31:0]  core_digits;
  logic         prev_msg, computing;
  logic         hold_ready = 1'b0;
  int unsigned  delay;

  assign key_bit  = key_mem[key_idx];
  assign core_bcd = core_digits[{core_sel, 2'b00} +: 4];

  always @(posedge clk) begin
    if (rst) begin
      core_ready  <= 1'b0;
      computing   <= 1'b0;
      prev_msg    <= 1'b0;
      core_digits <= '0;
    end else begin
      prev_msg <= core_msg_en;
      if (core_key_en) ksr <= {ksr[158:0], core_data};
      if (core_msg_en) msr <= {msr[62:0], core_data};
      if (prev_msg && !core_msg_en) begin
        core_digits <= totp_ref(ksr, msr);
        computing   <= 1'b1;
        delay       <= $urandom_range(0, 6);
      end else if (computing && !hold_ready) begin
        if (delay == 0) begin
          core_ready <= 1'b1;
          computing  <= 1'b0;
        end else begin
          delay <= delay - 1;
        end
      end
      if (core_key_en) begin
        core_ready <= 1'b0;
        computing  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (core_key_en) key_cnt++;
    if (core_msg_en) msg_cnt++;
    if (busy && !core_key_en && !core_msg_en) wait_cnt++;
    if (busy && !prev_busy) runs++;
    prev_busy = busy;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_run(input string name);
    int n;
    logic seen;
    n = 0;
    while (!busy && n < 8) begin @(negedge clk); n++; end
    seen = busy;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    check({name, " run_done"}, {62'd0, seen, busy}, 64'd2);
  endtask

  task automatic load_t(input logic [63:0] v);
    t_value = v; t_load = 1'b1;
    @(negedge clk);
    t_load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  typedef struct {
    logic [63:0] t;
    logic [23:0] code;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] tr;
    int n;
    vecs[0] = '{64'h1,        24'h287082};
    vecs[1] = '{64'h023523EC, 24'h081804};
    vecs[2] = '{64'h023523ED, 24'h050471};
    vecs[3] = '{64'h0273EF07, 24'h005924};
    vecs[4] = '{64'h03F940AA, 24'h279037};
    vecs[5] = '{64'h27BC86AA, 24'h353130};

    rst = 1'b1; tick = 1'b0; start = 1'b0; t_load = 1'b0; t_value = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst busy",      {63'd0, busy},        64'd0);
    check("rst valid",     {63'd0, valid},       64'd0);
    check("rst code",      {40'd0, code},        64'd0);
    check("rst timeout",   {63'd0, timeout_err}, 64'd0);
    check("rst step",      step,                 64'd0);
    check("rst key_idx",   {56'd0, key_idx},     64'd159);
    check("rst core_sel",  {61'd0, core_sel},    64'd0);
    check("rst enables",   {61'd0, core_key_en, core_msg_en, core_data}, 64'd0);

    // RFC 6238 vectors (6-digit truncation of the SHA1 table)
    for (int unsigned i = 0; i < 6; i++) begin
      key_cnt = 0; msg_cnt = 0;
      load_t(vecs[i].t);
      wait_run("rfc");
      check("rfc code",    {40'd0, code},  {40'd0, vecs[i].code});
      check("rfc valid",   {63'd0, valid}, 64'd1);
      check("rfc key_en",  64'(key_cnt),   64'd160);
      check("rfc msg_en",  64'(msg_cnt),   64'd64);
      check("rfc step",    step,           vecs[i].t);
    end

    // random T values, loaded then recomputed via start
    for (int unsigned r = 0; r < 4; r++) begin
      tr = {$urandom, $urandom};
      load_t(tr);
      wait_run("rand load");
      check("rand code", {40'd0, code}, {40'd0, exp_code(tr)});
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_start();
      wait_run("rand start");
      check("rand restart code", {40'd0, code},  {40'd0, exp_code(tr)});
      check("rand valid",        {63'd0, valid}, 64'd1);
    end

    // three ticks roll T from 5 to 6 and trigger exactly one run
    load_t(64'd5);
    wait_run("tick pre");
    runs = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i == 2) check("tick no early step", step, 64'd5);
      do_tick();
    end
    wait_run("tick");
    repeat (10) @(negedge clk);
    check("tick step", step,          64'd6);
    check("tick runs", 64'(runs),     64'd1);
    check("tick code", {40'd0, code}, {40'd0, exp_code(64'd6)});

    // t_load beats a wrapping tick in the same cycle
    load_t(64'd100);
    wait_run("prio pre");
    do_tick(); do_tick();
    tick = 1'b1;
    load_t(64'd200);
    tick = 1'b0;
    wait_run("prio");
    check("prio step", step,          64'd200);
    check("prio code", {40'd0, code}, {40'd0, exp_code(64'd200)});

    // T wraps from all-ones to zero
    load_t('1);
    wait_run("wrap pre");
    do_tick(); do_tick(); do_tick();
    wait_run("wrap");
    check("wrap step", step,          64'd0);
    check("wrap code", {40'd0, code}, {40'd0, exp_code(64'd0)});

    // two starts during KEY: one extra run, busy low for one cycle between
    runs = 0;
    pulse_start();
    n = 0;
    while (!busy && n < 8) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    check("dbl in key", {63'd0, core_key_en}, 64'd1);
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    check("dbl busy gap", 64'(n), 64'd1);
    wait_run("dbl second");
    repeat (20) @(negedge clk);
    check("dbl runs", 64'(runs),     64'd2);
    check("dbl code", {40'd0, code}, {40'd0, exp_code(64'd0)});

    // core never ready: timeout after exactly TIMEOUT WAIT cycles
    hold_ready = 1'b1;
    wait_cnt   = 0;
    pulse_start();
    wait_run("timeout");
    check("to wait cycles", 64'(wait_cnt),       64'(TIMEOUT));
    check("to err",         {63'd0, timeout_err}, 64'd1);
    check("to valid",       {63'd0, valid},       64'd0);
    hold_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("to err sticky",  {63'd0, timeout_err}, 64'd1);
    pulse_start();
    n = 0;
    while (!busy && n < 8) begin @(negedge clk); n++; end
    check("to err cleared", {63'd0, timeout_err}, 64'd0);
    wait_run("to recover");
    check("to recover valid", {63'd0, valid}, 64'd1);
    check("to recover code",  {40'd0, code},  {40'd0, exp_code(64'd0)});

    // reset in the middle of MSG (idx = 20)
    tr = {$urandom, $urandom};
    load_t(tr);
    n = 0;
    while (!core_msg_en && n < 400) begin @(negedge clk); n++; end
    repeat (43) @(negedge clk);
    check("mid msg_en", {63'd0, core_msg_en}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst busy",     {63'd0, busy},        64'd0);
    check("mrst enables",  {61'd0, core_key_en, core_msg_en, core_data}, 64'd0);
    check("mrst code",     {40'd0, code},        64'd0);
    check("mrst step",     step,                 64'd0);
    check("mrst valid",    {63'd0, valid},       64'd0);
    check("mrst key_idx",  {56'd0, key_idx},     64'd159);
    check("mrst core_sel", {61'd0, core_sel},    64'd0);
    repeat (5) @(negedge clk);
    check("mrst stays idle", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
